// File: rtl/vm_pkg.sv
// Mode codes shared by the vending-machine mode FSM and its input front end,
// plus the predicate that marks the self-terminating display states.
package vm_pkg;

  typedef enum logic [3:0] {
    S_OFF       = 4'b0000,
    S_INQUIRE   = 4'b0001,
    S_SELECT    = 4'b0010,
    S_PAY       = 4'b0011,
    S_ADM_MENU  = 4'b0100,
    S_ADM_EDIT  = 4'b0101,
    S_DISPENSE  = 4'b0110,
    S_CHANGE    = 4'b0111,
    S_REFUND    = 4'b1000,
    S_SOLD_OUT  = 4'b1001,
    S_NO_CHANGE = 4'b1010,
    S_PAY_FAIL  = 4'b1011,
    S_ADM_STOCK = 4'b1100,
    S_ADM_PRICE = 4'b1101,
    S_ADM_SAVED = 4'b1110,
    S_OUT       = 4'b1111
  } vm_state_e;

  function automatic logic is_transient(input logic [3:0] code);
    logic result;
    case (code)
      S_DISPENSE, S_CHANGE, S_ADM_SAVED, S_NO_CHANGE,
      S_PAY_FAIL, S_SOLD_OUT, S_REFUND: result = 1'b1;
      default:                          result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debounce and a
// single-cycle indication of an accepted 0->1 change.
module key_debounce #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          acc_r;
  logic          acc_d_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, then accept the new level only after it has differed
  // from the accepted one for DB_CYCLES consecutive clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      acc_r   <= 1'b0;
      acc_d_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      acc_d_r <= acc_r;
      if (sync2_r == acc_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        acc_r <= sync2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign rise = acc_r & ~acc_d_r;

endmodule

// File: rtl/vm_input_ctrl.sv
// Vending-machine input front end: debounced key pulses with priority,
// synchronised slide switches, transient-state timeout and idle auto-rotate.
module vm_input_ctrl
  import vm_pkg::*;
#(
  parameter int DB_CYCLES     = 2_000_000,
  parameter int FINISH_CYCLES = 300_000_000,
  parameter int ROTATE_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_confirm,
  input  logic       btn_return,
  input  logic       btn_plus,
  input  logic       btn_minus,
  input  logic       sw_main,
  input  logic       sw_adm,
  input  logic [3:0] state,
  output logic       confirm,
  output logic       ret,
  output logic       switch_plus,
  output logic       switch_minus,
  output logic       main_switch,
  output logic       adm_mode,
  output logic       finish
);

  localparam int FW = (FINISH_CYCLES > 1) ? $clog2(FINISH_CYCLES) : 1;
  localparam int RW = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;
  localparam logic [FW-1:0] FIN_LAST = FW'(FINISH_CYCLES - 1);
  localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_CYCLES - 1);

  logic          rise_confirm_s, rise_return_s, rise_plus_s, rise_minus_s;
  logic          key_confirm_s, key_return_s, key_plus_s, key_minus_s, key_any_s;
  logic          changed_s, transient_s, inquire_s, fin_fire_s, auto_s;
  logic [1:0]    sw_meta_r;
  logic [3:0]    state_d_r;
  logic [FW-1:0] fin_cnt_r;
  logic          fin_done_r;
  logic [RW-1:0] rot_cnt_r;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_confirm (
    .clk(clk), .rst_n(rst_n), .raw(btn_confirm), .rise(rise_confirm_s));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_return (
    .clk(clk), .rst_n(rst_n), .raw(btn_return), .rise(rise_return_s));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_plus (
    .clk(clk), .rst_n(rst_n), .raw(btn_plus), .rise(rise_plus_s));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_minus (
    .clk(clk), .rst_n(rst_n), .raw(btn_minus), .rise(rise_minus_s));

  // Key arbitration and timeout/rotate fire conditions; losing keys are dropped.
  always_comb begin
    changed_s     = (state != state_d_r);
    transient_s   = is_transient(state);
    inquire_s     = (state == S_INQUIRE);
    key_confirm_s = 1'b0;
    key_return_s  = 1'b0;
    key_plus_s    = 1'b0;
    key_minus_s   = 1'b0;
    if (state == S_OFF) begin
      key_return_s = 1'b0;
    end else if (rise_return_s) begin
      key_return_s = 1'b1;
    end else if (rise_confirm_s) begin
      key_confirm_s = 1'b1;
    end else if (rise_minus_s) begin
      key_minus_s = 1'b1;
    end else if (rise_plus_s) begin
      key_plus_s = 1'b1;
    end else begin
      key_return_s = 1'b0;
    end
    key_any_s  = key_confirm_s | key_return_s | key_plus_s | key_minus_s;
    fin_fire_s = transient_s & ~changed_s & ~fin_done_r & (fin_cnt_r == FIN_LAST);
    auto_s     = inquire_s & ~changed_s & ~key_any_s & (rot_cnt_r == ROT_LAST);
  end

  // Switch synchroniser, state history and the two dwell counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r   <= 2'b00;
      main_switch <= 1'b0;
      adm_mode    <= 1'b0;
      state_d_r   <= 4'b0000;
      fin_cnt_r   <= '0;
      fin_done_r  <= 1'b0;
      rot_cnt_r   <= '0;
    end else begin
      sw_meta_r   <= {sw_main, sw_adm};
      main_switch <= sw_meta_r[1];
      adm_mode    <= sw_meta_r[0];
      state_d_r   <= state;
      if (!transient_s || changed_s) begin
        fin_cnt_r  <= '0;
        fin_done_r <= 1'b0;
      end else if (fin_cnt_r == FIN_LAST) begin
        fin_done_r <= 1'b1;
      end else begin
        fin_cnt_r <= fin_cnt_r + FW'(1);
      end
      if (!inquire_s || changed_s || key_any_s || (rot_cnt_r == ROT_LAST)) begin
        rot_cnt_r <= '0;
      end else begin
        rot_cnt_r <= rot_cnt_r + RW'(1);
      end
    end
  end

  // Registered pulse outputs; a timeout pulse suppresses any key pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      confirm      <= 1'b0;
      ret          <= 1'b0;
      switch_plus  <= 1'b0;
      switch_minus <= 1'b0;
      finish       <= 1'b0;
    end else if (fin_fire_s) begin
      confirm      <= 1'b0;
      ret          <= 1'b0;
      switch_plus  <= 1'b0;
      switch_minus <= 1'b0;
      finish       <= 1'b1;
    end else begin
      confirm      <= key_confirm_s;
      ret          <= key_return_s;
      switch_plus  <= key_plus_s | auto_s;
      switch_minus <= key_minus_s;
      finish       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vm_input_ctrl.sv
// Directed bench for vm_input_ctrl: a table of held-input segments with
// expected pulse counts, plus exact-timing sequences for the multi-cycle cases.
module tb_vm_input_ctrl;

  localparam int DB  = 4;
  localparam int FIN = 10;
  localparam int ROT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_confirm, btn_return, btn_plus, btn_minus;
  logic       sw_main, sw_adm;
  logic [3:0] state;
  logic       confirm, ret, switch_plus, switch_minus, main_switch, adm_mode, finish;

  always #5 clk = ~clk;

  vm_input_ctrl #(.DB_CYCLES(DB), .FINISH_CYCLES(FIN), .ROTATE_CYCLES(ROT)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_confirm(btn_confirm), .btn_return(btn_return),
    .btn_plus(btn_plus), .btn_minus(btn_minus),
    .sw_main(sw_main), .sw_adm(sw_adm), .state(state),
    .confirm(confirm), .ret(ret), .switch_plus(switch_plus),
    .switch_minus(switch_minus), .main_switch(main_switch),
    .adm_mode(adm_mode), .finish(finish));

  typedef struct {
    logic [3:0] btn;   // {ret, confirm, minus, plus}
    logic [1:0] sw;    // {main, adm}
    logic [3:0] st;
    int         cycles;
    int         e_conf, e_ret, e_plus, e_minus, e_fin;
    logic [1:0] e_sw;
  } vec_t;

  vec_t       vecs[$];
  int         applied = 0;
  int         miscompares = 0;
  int         onehot_err = 0;
  logic [4:0] p;       // {confirm, ret, switch_plus, switch_minus, finish}

  function automatic vec_t mk(input logic [3:0] b, input logic [1:0] s, input logic [3:0] st,
                              input int cyc, input int c, input int r, input int pl,
                              input int mi, input int f, input logic [1:0] esw);
    vec_t v;
    v.btn = b; v.sw = s; v.st = st; v.cycles = cyc;
    v.e_conf = c; v.e_ret = r; v.e_plus = pl; v.e_minus = mi; v.e_fin = f; v.e_sw = esw;
    return v;
  endfunction

  function automatic logic [14:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {a[2:0], b[2:0], c[2:0], d[2:0], e[2:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] b, input logic [1:0] s, input logic [3:0] st);
    {btn_return, btn_confirm, btn_minus, btn_plus} = b;
    {sw_main, sw_adm} = s;
    state = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    p = {confirm, ret, switch_plus, switch_minus, finish};
    if ($countones(p) > 1) onehot_err++;
  endtask

  task automatic settle();
    drive(4'b0000, 2'b00, 4'b0010);
    repeat (12) step();
  endtask

  initial begin
    int c_conf, c_ret, c_plus, c_minus, c_fin;
    int pos_a, pos_b, cnt_a, cnt_b;
    logic pat [8];
    vec_t v;

    // Segments run back to back; counts are pulses seen during each segment.
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0000, 10, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b1111, 2'b11, 4'b0000, 12, 0, 0, 0, 0, 0, 2'b11));
    vecs.push_back(mk(4'b1111, 2'b01, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b01));
    vecs.push_back(mk(4'b0000, 2'b10, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b10));
    vecs.push_back(mk(4'b0100, 2'b00, 4'b0010, 12, 1, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0100, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0010, 2'b00, 4'b0010, 12, 0, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0001, 2'b00, 4'b0010, 12, 0, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b1000, 2'b00, 4'b0010, 12, 0, 1, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b1001, 2'b00, 4'b0010, 12, 0, 1, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0110, 2'b00, 4'b0010, 12, 1, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0011, 2'b00, 4'b0010, 12, 0, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0110, 12, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0110, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0111, 12, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b1110, 12, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b1010, 12, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b1011, 12, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b1001, 12, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b1000, 12, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0011, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0100, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0101, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b1100, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b1101, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b1111, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0001, 25, 0, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(4'b0100, 2'b00, 4'b1000, 12, 1, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(4'b0000, 2'b00, 4'b0010, 12, 0, 0, 0, 0, 0, 2'b00));

    rst_n = 1'b0;
    drive(4'b0000, 2'b00, 4'b0000);
    #12;
    check("reset_outputs",
          {25'd0, confirm, ret, switch_plus, switch_minus, finish, main_switch, adm_mode}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.btn, v.sw, v.st);
      c_conf = 0; c_ret = 0; c_plus = 0; c_minus = 0; c_fin = 0;
      for (int t = 0; t < v.cycles; t++) begin
        step();
        c_conf  += int'(p[4]);
        c_ret   += int'(p[3]);
        c_plus  += int'(p[2]);
        c_minus += int'(p[1]);
        c_fin   += int'(p[0]);
      end
      check($sformatf("vec%0d_pulses", i), {17'd0, pk(c_conf, c_ret, c_plus, c_minus, c_fin)},
            {17'd0, pk(v.e_conf, v.e_ret, v.e_plus, v.e_minus, v.e_fin)});
      check($sformatf("vec%0d_switches", i), {30'd0, main_switch, adm_mode}, {30'd0, v.e_sw});
    end

    // Bouncing confirm in inquire: one pulse, 7 clocks after the final rising edge.
    settle();
    state = 4'b0001;
    step();
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++) begin
      btn_confirm = pat[k];
      step();
    end
    btn_confirm = 1'b1;
    pos_a = -1; cnt_a = 0;
    for (int t = 1; t <= 50; t++) begin
      step();
      if (p[4]) begin
        cnt_a++;
        if (pos_a < 0) pos_a = t;
      end
    end
    check("bounce_confirm_pos", pos_a, 7);
    check("bounce_confirm_cnt", cnt_a, 1);

    // Finish after a full dwell in 0110.
    settle();
    state = 4'b0110;
    pos_a = -1; cnt_a = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (p[0]) begin
        cnt_a++;
        if (pos_a < 0) pos_a = t;
      end
    end
    check("finish_dwell_pos", pos_a, 10);
    check("finish_dwell_cnt", cnt_a, 1);

    // Moving to 0111 at clock 5 restarts the dwell.
    settle();
    state = 4'b0110;
    pos_a = -1; cnt_a = 0;
    for (int t = 0; t < 5; t++) begin
      step();
      cnt_a += int'(p[0]);
    end
    state = 4'b0111;
    for (int t = 0; t < 20; t++) begin
      step();
      if (p[0]) begin
        cnt_a++;
        if (pos_a < 0) pos_a = t;
      end
    end
    check("finish_restart_pos", pos_a, 10);
    check("finish_restart_cnt", cnt_a, 1);

    // Idle inquire: automatic next-item steps at clocks 20 and 40.
    settle();
    state = 4'b0001;
    pos_a = -1; pos_b = -1; cnt_a = 0;
    for (int t = 0; t < 45; t++) begin
      step();
      if (p[2]) begin
        cnt_a++;
        if (pos_a < 0) pos_a = t;
        else if (pos_b < 0) pos_b = t;
      end
    end
    check("rotate_first", pos_a, 20);
    check("rotate_second", pos_b, 40);
    check("rotate_cnt", cnt_a, 2);

    // A minus key at clock 15 restarts the rotate interval.
    settle();
    state = 4'b0001;
    pos_a = -1; pos_b = -1; cnt_a = 0; cnt_b = 0;
    for (int t = 0; t < 45; t++) begin
      step();
      if (p[1]) begin
        cnt_b++;
        if (pos_b < 0) pos_b = t;
      end
      if (p[2]) begin
        cnt_a++;
        if (pos_a < 0) pos_a = t;
      end
      if (t == 8) btn_minus = 1'b1;
      if (t == 25) btn_minus = 1'b0;
    end
    check("rotate_key_minus_pos", pos_b, 15);
    check("rotate_key_minus_cnt", cnt_b, 1);
    check("rotate_after_key_pos", pos_a, 35);
    check("rotate_after_key_cnt", cnt_a, 1);

    // Reset at finish count 7, confirm held across reset.
    settle();
    drive(4'b0000, 2'b11, 4'b0110);
    for (int t = 0; t < 8; t++) step();
    check("sw_before_reset", {30'd0, main_switch, adm_mode}, 32'd3);
    #2;
    rst_n = 1'b0;
    btn_confirm = 1'b1;
    #1;
    check("reset_async_clear",
          {25'd0, confirm, ret, switch_plus, switch_minus, finish, main_switch, adm_mode}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos_a = -1; cnt_a = 0; cnt_b = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (t == 0) check("sw_sync_lat1", {31'd0, main_switch}, 32'd0);
      if (t == 1) check("sw_sync_lat2", {31'd0, main_switch}, 32'd1);
      if (p[0]) begin
        cnt_a++;
        if (pos_a < 0) pos_a = t;
      end
      cnt_b += int'(p[4]);
    end
    check("post_reset_finish_pos", pos_a, 10);
    check("post_reset_finish_cnt", cnt_a, 1);
    check("post_reset_held_confirm", cnt_b, 1);

    check("onehot_outputs", onehot_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/vm_input_ctrl.md
VM_INPUT_CTRL -- requirements
Module: vm_input_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 2_000_000; stable clocks required before a button level is accepted (20 ms at 100 MHz).
REQ-002 Parameter FINISH_CYCLES, default 300_000_000; dwell in a transient display state before finish fires.
REQ-003 Parameter ROTATE_CYCLES, default 500_000_000; idle time in inquire before an automatic next-item step.
REQ-004 Ports: one clock; reset is asynchronous and active-low: clk input 1 system clock; rst_n input 1 async active-low reset.
REQ-005 btn_confirm, btn_return, btn_plus, btn_minus  input  1  raw, asynchronous, bouncing push-buttons, active-high.
REQ-006 sw_main, sw_adm  input  1  raw level slide switches.
REQ-007 state  input  4  current mode code from the mode FSM.
REQ-008 confirm, ret, switch_plus, switch_minus  output  1  single-cycle key pulses.
REQ-009 main_switch, adm_mode  output  1  synchronised switch levels.
REQ-010 finish  output  1  single-cycle timeout pulse for transient states.

Function
REQ-011 Every raw input SHALL pass a 2-flop synchroniser before any other use.
REQ-012 main_switch/adm_mode SHALL equal the synchroniser output (latency 2 clocks, no debounce).
REQ-013 Per button: counter clears whenever synced level equals accepted level; when differing for DB_CYCLES consecutive clocks, the accepted level SHALL update.
REQ-014 A 0->1 change of an accepted level SHALL produce one pulse on the next clock; holding a button SHALL never produce a second pulse; release produces nothing.
REQ-015 Simultaneous accepted rises SHALL emit only one pulse, priority ret > confirm > switch_minus > switch_plus; losers are dropped.
REQ-016 Transient states: 0110, 0111, 1110, 1010, 1011, 1001, 1000.
REQ-017 Finish counter SHALL clear on any change of state; while state is transient it counts, and at count FINISH_CYCLES-1 finish SHALL pulse once, then counter holds until state changes.
REQ-018 Finish SHALL never pulse in non-transient states, nor twice in one state visit.
REQ-019 In state 0001 (inquire) a rotate counter SHALL run; at ROTATE_CYCLES-1 it SHALL pulse switch_plus once and restart from 0.
REQ-020 Any key pulse or state change SHALL restart the rotate counter; an auto pulse coinciding with a key pulse is suppressed.
REQ-021 In state 0000 (off) all pulse outputs SHALL be 0 and finish/rotate counters held at 0; debouncers keep running.
REQ-022 Counter widths SHALL be $clog2 of their parameter; no counter may wrap.
REQ-023 At most one of confirm, ret, switch_plus, switch_minus, finish high per clock; finish has top priority and the key pulse in that clock is dropped.

Reset
REQ-024 rst_n low SHALL asynchronously clear synchronisers, accepted levels, all counters and all outputs to 0.
REQ-025 After release, a button already held SHALL NOT pulse until released and pressed again (accepted level starts 0, so held button pulses once after debounce -- this SHALL be the single allowed exception).
REQ-026 Reset mid-count SHALL discard the count; no pulse emitted after release from pre-reset progress.

Structure
REQ-027 The 4-bit state codes (S_OFF ... S_OUT) and the transient-state predicate SHALL live in shared package vm_pkg, used by the mode FSM and this block.
REQ-028 One sub-module key_debounce (synchroniser + debounce + rise pulse) SHALL be instantiated four times.

Verification
REQ-029 Use DB_CYCLES=4, FINISH_CYCLES=10, ROTATE_CYCLES=20.
REQ-030 btn_confirm bounces 3 times then held 50 clocks, state=0001 -> exactly one confirm pulse, 2+4+1 clocks after last edge.
REQ-031 btn_return and btn_plus rise same clock, stable -> only ret pulses; switch_plus stays 0.
REQ-032 state set to 0110 and held 30 clocks -> finish pulses once, at clock 10 after entry; state changed to 0111 at clock 5 instead -> finish 10 clocks after the change.
REQ-033 state=0001, no keys, 45 clocks -> switch_plus at clocks 20 and 40; switch_minus pulse at clock 15 -> next auto pulse at clock 35.
REQ-034 state=0000, buttons pressed -> all pulse outputs stay 0; rst_n asserted at finish count 7 -> outputs 0 immediately, no finish after release until a full 10-clock dwell.
